// File: rtl/cache_refill_arbiter.sv
// Arbitrates the single AXI read channel between the I-cache and D-cache refill FSMs:
// one INCR line-fill burst per grant, R beats steered combinationally to the winner.
module cache_refill_arbiter #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          LINE_BEATS = 16,
    parameter logic [3:0]  ID_I       = 4'd0,
    parameter logic [3:0]  ID_D       = 4'd1
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              i_r_req,
    input  logic [ADDR_W-1:0] i_r_addr,
    output logic              i_r_rdy,
    output logic [DATA_W-1:0] i_r_data,
    output logic              i_r_dvalid,
    output logic              i_r_dlast,
    input  logic              i_r_dready,

    input  logic              d_r_req,
    input  logic [ADDR_W-1:0] d_r_addr,
    output logic              d_r_rdy,
    output logic [DATA_W-1:0] d_r_data,
    output logic              d_r_dvalid,
    output logic              d_r_dlast,
    input  logic              d_r_dready,

    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,

    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    output logic              rerr
);

    localparam int OFF_W = $clog2(LINE_BEATS * DATA_W / 8);
    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    typedef enum logic {
        G_I = 1'b0,
        G_D = 1'b1
    } grant_e;

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            pick;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              rerr_q, rerr_d;
    logic              r_ready;

    // NOTE: state registers use non-blocking assignments only, so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            grant_q      <= G_I;
            last_grant_q <= G_D;
            araddr_q     <= '0;
            beat_cnt_q   <= '0;
            rerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            beat_cnt_q   <= beat_cnt_d;
            rerr_q       <= rerr_d;
        end
    end

    // NOTE: every variable written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        beat_cnt_d   = beat_cnt_q;
        rerr_d       = rerr_q;
        pick         = G_I;
        r_ready      = 1'b0;
        arvalid      = 1'b0;
        i_r_rdy      = 1'b0;
        d_r_rdy      = 1'b0;
        i_r_dvalid   = 1'b0;
        i_r_dlast    = 1'b0;
        d_r_dvalid   = 1'b0;
        d_r_dlast    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_r_req || d_r_req) begin
                    // On a tie, favour the cache that did not win last time.
                    if (i_r_req && d_r_req) begin
                        pick = (last_grant_q == G_I) ? G_D : G_I;
                    end else begin
                        pick = d_r_req ? G_D : G_I;
                    end
                    grant_d      = pick;
                    last_grant_d = pick;
                    araddr_d     = ((pick == G_D) ? d_r_addr : i_r_addr) & LINE_MASK;
                    state_d      = S_AR;
                end
            end

            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    i_r_rdy = (grant_q == G_I);
                    d_r_rdy = (grant_q == G_D);
                    state_d = S_R;
                end
            end

            S_R: begin
                if (grant_q == G_D) begin
                    r_ready    = d_r_dready;
                    d_r_dvalid = rvalid;
                    d_r_dlast  = rlast;
                end else begin
                    r_ready    = i_r_dready;
                    i_r_dvalid = rvalid;
                    i_r_dlast  = rlast;
                end
                if (rvalid && r_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (rresp != 2'b00) begin
                        rerr_d = 1'b1;
                    end
                    // rlast alone terminates the burst; the beat count is informational.
                    if (rlast) begin
                        beat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rready   = r_ready;
    assign i_r_data = rdata;
    assign d_r_data = rdata;
    assign araddr   = araddr_q;
    assign arid     = (grant_q == G_D) ? ID_D : ID_I;
    assign arlen    = 8'(LINE_BEATS - 1);
    assign arsize   = 3'($clog2(DATA_W / 8));
    assign arburst  = 2'b01;
    assign rerr     = rerr_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: a cycle-by-cycle vector table for grant and
// handshake behaviour, plus hand-written sequences for bursts, errors and reset.
module tb_cache_refill_arbiter;

    localparam logic [31:0] I_ADDR = 32'h1000_0034;
    localparam logic [31:0] D_ADDR = 32'h2000_0148;
    localparam logic [31:0] I_LINE = 32'h1000_0000;
    localparam logic [31:0] D_LINE = 32'h2000_0140;

    logic        clk;
    logic        rstn;
    logic        i_r_req, d_r_req;
    logic [31:0] i_r_addr, d_r_addr;
    logic        i_r_rdy, d_r_rdy;
    logic [31:0] i_r_data, d_r_data;
    logic        i_r_dvalid, d_r_dvalid, i_r_dlast, d_r_dlast;
    logic        i_r_dready, d_r_dready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast, rerr;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int nvec = 0;
    int nmis = 0;

    cache_refill_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_r_req    (i_r_req),
        .i_r_addr   (i_r_addr),
        .i_r_rdy    (i_r_rdy),
        .i_r_data   (i_r_data),
        .i_r_dvalid (i_r_dvalid),
        .i_r_dlast  (i_r_dlast),
        .i_r_dready (i_r_dready),
        .d_r_req    (d_r_req),
        .d_r_addr   (d_r_addr),
        .d_r_rdy    (d_r_rdy),
        .d_r_data   (d_r_data),
        .d_r_dvalid (d_r_dvalid),
        .d_r_dlast  (d_r_dlast),
        .d_r_dready (d_r_dready),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arid       (arid),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rlast      (rlast),
        .rresp      (rresp),
        .rerr       (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
        $fatal(1, "watchdog expired");
    end

    // Stimulus order: ireq dreq arready rvalid rlast rresp[1:0] i_dready d_dready
    typedef struct packed {
        logic       ireq;
        logic       dreq;
        logic       arready;
        logic       rvalid;
        logic       rlast;
        logic [1:0] rresp;
        logic       idr;
        logic       ddr;
    } stim_t;

    // Expectation order: arvalid grant(1=D) i_rdy d_rdy rready i_dv d_dv i_dl d_dl
    typedef struct packed {
        logic arvalid;
        logic agnt;
        logic irdy;
        logic drdy;
        logic rready;
        logic idv;
        logic ddv;
        logic idl;
        logic ddl;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Feed n beats to the granted cache; optional stall window and error beat.
    task automatic beat_burst(input logic to_d, input int n, input int err_beat,
                              input int stall_lo, input int stall_hi);
        for (int b = 1; b <= n; b++) begin
            logic [31:0] dat;
            dat    = (to_d ? 32'hD000_0000 : 32'hC000_0000) + 32'(b);
            rvalid = 1'b1;
            rdata  = dat;
            rlast  = (b == n);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            if (b >= stall_lo && b <= stall_hi) begin
                i_r_dready = 1'b0;
                d_r_dready = 1'b0;
                #1;
                check($sformatf("stall%0d_rready", b), 64'(rready), 64'd0);
                check($sformatf("stall%0d_dvalid", b),
                      64'(to_d ? d_r_dvalid : i_r_dvalid), 64'd1);
                next_cycle();
            end
            i_r_dready = ~to_d;
            d_r_dready = to_d;
            #1;
            check($sformatf("beat%0d_rready", b), 64'(rready), 64'd1);
            check($sformatf("beat%0d_data", b), 64'(to_d ? d_r_data : i_r_data), 64'(dat));
            check($sformatf("beat%0d_dlast", b),
                  64'(to_d ? d_r_dlast : i_r_dlast), 64'(b == n));
            check($sformatf("beat%0d_other_dvalid", b),
                  64'(to_d ? i_r_dvalid : d_r_dvalid), 64'd0);
            if (err_beat > 0) begin
                check($sformatf("beat%0d_rerr", b), 64'(rerr), 64'(b > err_beat));
            end
            next_cycle();
        end
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = 2'b00;
        i_r_dready = 1'b0;
        d_r_dready = 1'b0;
    endtask

    function automatic vec_t mk(input logic [8:0] s, input logic [8:0] e);
        vec_t v;
        v.s = s;
        v.e = e;
        return v;
    endfunction

    initial begin
        logic [63:0] act, exp;

        // Ties, single requests, stalled last beats and beats outside R.
        tbl[0]  = mk(9'b1_1_0_0_0_00_0_0, 9'b0_0_0_0_0_0_0_0_0);
        tbl[1]  = mk(9'b1_1_1_0_0_00_0_0, 9'b1_0_1_0_0_0_0_0_0);
        tbl[2]  = mk(9'b0_1_0_1_1_00_1_0, 9'b0_0_0_0_1_1_0_1_0);
        tbl[3]  = mk(9'b0_1_0_0_0_00_0_0, 9'b0_0_0_0_0_0_0_0_0);
        tbl[4]  = mk(9'b0_1_1_0_0_00_0_0, 9'b1_1_0_1_0_0_0_0_0);
        tbl[5]  = mk(9'b1_0_0_1_1_00_1_1, 9'b0_0_0_0_1_0_1_0_1);
        tbl[6]  = mk(9'b1_1_0_0_0_00_0_0, 9'b0_0_0_0_0_0_0_0_0);
        tbl[7]  = mk(9'b1_1_0_0_0_00_0_0, 9'b1_0_0_0_0_0_0_0_0);
        tbl[8]  = mk(9'b1_1_1_0_0_00_0_0, 9'b1_0_1_0_0_0_0_0_0);
        tbl[9]  = mk(9'b0_1_0_1_1_00_0_0, 9'b0_0_0_0_0_1_0_1_0);
        tbl[10] = mk(9'b0_1_0_1_1_00_1_0, 9'b0_0_0_0_1_1_0_1_0);
        tbl[11] = mk(9'b1_1_0_0_0_00_0_0, 9'b0_0_0_0_0_0_0_0_0);
        tbl[12] = mk(9'b1_1_1_0_0_00_0_0, 9'b1_1_0_1_0_0_0_0_0);
        tbl[13] = mk(9'b1_0_0_1_1_00_0_1, 9'b0_0_0_0_1_0_1_0_1);
        tbl[14] = mk(9'b1_0_0_1_0_00_1_1, 9'b0_0_0_0_0_0_0_0_0);
        tbl[15] = mk(9'b1_0_0_1_0_00_1_0, 9'b1_0_0_0_0_0_0_0_0);
        tbl[16] = mk(9'b1_0_0_0_0_00_0_0, 9'b1_0_0_0_0_0_0_0_0);
        tbl[17] = mk(9'b1_0_0_0_0_00_0_0, 9'b1_0_0_0_0_0_0_0_0);
        tbl[18] = mk(9'b1_0_1_0_0_00_0_0, 9'b1_0_1_0_0_0_0_0_0);
        tbl[19] = mk(9'b0_0_0_0_0_00_1_0, 9'b0_0_0_0_1_0_0_0_0);
        tbl[20] = mk(9'b0_0_0_1_1_00_1_0, 9'b0_0_0_0_1_1_0_1_0);
        tbl[21] = mk(9'b0_0_0_0_0_00_0_0, 9'b0_0_0_0_0_0_0_0_0);

        rstn       = 1'b0;
        i_r_req    = 1'b0;
        d_r_req    = 1'b0;
        i_r_addr   = I_ADDR;
        d_r_addr   = D_ADDR;
        i_r_dready = 1'b0;
        d_r_dready = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = 2'b00;
        rdata      = 32'h0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;

        for (int k = 0; k < 22; k++) begin
            {i_r_req, d_r_req, arready, rvalid, rlast, rresp, i_r_dready, d_r_dready} = tbl[k].s;
            rdata = 32'hA5A5_0000 + 32'(k);
            #1;
            act = 64'({arvalid, arvalid ? arid : 4'h0, i_r_rdy, d_r_rdy, rready,
                       i_r_dvalid, d_r_dvalid, i_r_dlast, d_r_dlast, rerr,
                       arvalid ? araddr : 32'h0});
            exp = 64'({tbl[k].e.arvalid,
                       tbl[k].e.arvalid ? (tbl[k].e.agnt ? 4'd1 : 4'd0) : 4'h0,
                       tbl[k].e.irdy, tbl[k].e.drdy, tbl[k].e.rready,
                       tbl[k].e.idv, tbl[k].e.ddv, tbl[k].e.idl, tbl[k].e.ddl, 1'b0,
                       tbl[k].e.arvalid ? (tbl[k].e.agnt ? D_LINE : I_LINE) : 32'h0});
            check($sformatf("vec%0d", k), act, exp);
            if (tbl[k].e.idv) check($sformatf("vec%0d_idata", k), 64'(i_r_data), 64'(rdata));
            if (tbl[k].e.ddv) check($sformatf("vec%0d_ddata", k), 64'(d_r_data), 64'(rdata));
            next_cycle();
        end
        {i_r_req, d_r_req, arready, rvalid, rlast, rresp, i_r_dready, d_r_dready} = '0;

        // D burst of 16 beats with the D-cache stalling on beats 3-5.
        d_r_req = 1'b1;
        #1;
        check("d16_idle_arvalid", 64'(arvalid), 64'd0);
        next_cycle();
        arready = 1'b1;
        #1;
        check("d16_handshake", 64'({arvalid, d_r_rdy, i_r_rdy, arid, araddr}),
              64'({1'b1, 1'b1, 1'b0, 4'd1, D_LINE}));
        check("d16_ar_consts", 64'({arlen, arsize, arburst}),
              64'({8'd15, 3'd2, 2'b01}));
        next_cycle();
        d_r_req = 1'b0;
        arready = 1'b0;
        beat_burst(1'b1, 16, 0, 3, 5);
        rvalid = 1'b1;
        #1;
        check("d16_after_rready", 64'({rready, d_r_dvalid, arvalid}), 64'd0);
        rvalid = 1'b0;

        // Short D burst ending on beat 4 while an I request is pending.
        d_r_req = 1'b1;
        #1;
        check("short_idle_arvalid", 64'(arvalid), 64'd0);
        next_cycle();
        i_r_req = 1'b1;
        arready = 1'b1;
        #1;
        check("short_handshake", 64'({d_r_rdy, i_r_rdy, arid}), 64'({1'b1, 1'b0, 4'd1}));
        next_cycle();
        d_r_req = 1'b0;
        arready = 1'b0;
        beat_burst(1'b1, 4, 0, 0, -1);
        #1;
        check("turnaround_idle", 64'(arvalid), 64'd0);
        next_cycle();
        arready = 1'b1;
        #1;
        check("turnaround_ar", 64'({arvalid, arid, araddr, i_r_rdy}),
              64'({1'b1, 4'd0, I_LINE, 1'b1}));
        next_cycle();
        i_r_req = 1'b0;
        arready = 1'b0;

        // I burst with SLVERR on beat 7: rerr rises afterwards and sticks.
        beat_burst(1'b0, 16, 7, 0, -1);
        #1;
        check("rerr_sticky", 64'(rerr), 64'd1);

        // Reset asserted while in AR clears everything; tie afterwards goes to I.
        d_r_req = 1'b1;
        next_cycle();
        #1;
        check("pre_reset_arvalid", 64'(arvalid), 64'd1);
        rstn    = 1'b0;
        arready = 1'b1;
        rvalid  = 1'b1;
        d_r_dready = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs", 64'({arvalid, rready, i_r_rdy, d_r_rdy, rerr, d_r_dvalid}), 64'd0);
        @(negedge clk);
        rstn    = 1'b1;
        arready = 1'b0;
        i_r_req = 1'b1;
        #1;
        check("post_reset_idle", 64'({arvalid, rready}), 64'd0);
        next_cycle();
        #1;
        check("post_reset_tie", 64'({arvalid, arid, araddr}), 64'({1'b1, 4'd0, I_LINE}));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
